// File: rtl/miriscv_lsu.sv
// Load-store unit: turns decoder memory controls into a req/gnt/rvalid data-memory
// transaction, with byte enables, store-data replication and load-data extension.
module miriscv_lsu (
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic [31:0] lsu_data_o,
   output logic        lsu_stall_req_o,
   output logic        lsu_misaligned_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);
   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

   state_t      state_reg;
   logic        we_reg;
   logic [2:0]  size_reg;
   logic [1:0]  off_reg;
   logic [29:0] addr_reg;
   logic [3:0]  be_reg;
   logic [31:0] wdata_reg;
   logic [31:0] data_reg;

   logic        illegal;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic        idle;
   logic        issue;
   logic        rvalid_done;
   logic        done;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_fmt;

   always_comb begin
      illegal    = 1'b0;
      be_next    = 4'b0000;
      wdata_next = lsu_data_i;
      case (lsu_size_i)
         LDST_B, LDST_BU: begin
            be_next    = 4'b0001 << lsu_addr_i[1:0];
            wdata_next = {4{lsu_data_i[7:0]}};
         end
         LDST_H, LDST_HU: begin
            illegal    = lsu_addr_i[0];
            be_next    = 4'b0011 << {lsu_addr_i[1], 1'b0};
            wdata_next = {2{lsu_data_i[15:0]}};
         end
         LDST_W: begin
            illegal    = |lsu_addr_i[1:0];
            be_next    = 4'b1111;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign idle        = (state_reg == IDLE);
   assign issue       = idle && lsu_req_i && !illegal;
   assign rvalid_done = (state_reg == WAIT_RVALID) && data_rvalid_i;
   assign done        = (issue && data_gnt_i && lsu_we_i)
                     || ((state_reg == WAIT_GNT) && data_gnt_i && we_reg)
                     || rvalid_done;

   // Status outputs are masked while reset is held, even though inputs may be live.
   assign lsu_stall_req_o  = arstn_i && lsu_req_i && !illegal && !done;
   assign lsu_misaligned_o = arstn_i && idle && lsu_req_i && illegal;
   assign data_req_o       = arstn_i && (issue || (state_reg == WAIT_GNT));

   // First request cycle drives straight from the inputs; afterwards from the capture.
   assign data_we_o    = idle ? lsu_we_i   : we_reg;
   assign data_be_o    = idle ? be_next    : be_reg;
   assign data_addr_o  = idle ? {lsu_addr_i[31:2], 2'b00} : {addr_reg, 2'b00};
   assign data_wdata_o = idle ? wdata_next : wdata_reg;

   assign byte_sel = data_rdata_i[{off_reg, 3'b000} +: 8];
   assign half_sel = data_rdata_i[{off_reg[1], 4'b0000} +: 16];

   always_comb begin
      load_fmt = data_rdata_i;
      case (size_reg)
         LDST_B:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
         LDST_BU: load_fmt = {24'd0, byte_sel};
         LDST_H:  load_fmt = {{16{half_sel[15]}}, half_sel};
         LDST_HU: load_fmt = {16'd0, half_sel};
         default: load_fmt = data_rdata_i;
      endcase
   end

   assign lsu_data_o = rvalid_done ? load_fmt : data_reg;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_reg <= IDLE;
         we_reg    <= 1'b0;
         size_reg  <= 3'd0;
         off_reg   <= 2'd0;
         addr_reg  <= 30'd0;
         be_reg    <= 4'd0;
         wdata_reg <= 32'd0;
         data_reg  <= 32'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (issue) begin
                  we_reg    <= lsu_we_i;
                  size_reg  <= lsu_size_i;
                  off_reg   <= lsu_addr_i[1:0];
                  addr_reg  <= lsu_addr_i[31:2];
                  be_reg    <= be_next;
                  wdata_reg <= wdata_next;
                  if (!data_gnt_i)
                     state_reg <= WAIT_GNT;
                  else if (!lsu_we_i)
                     state_reg <= WAIT_RVALID;
               end
            end
            WAIT_GNT: begin
               if (data_gnt_i)
                  state_reg <= we_reg ? IDLE : WAIT_RVALID;
            end
            WAIT_RVALID: begin
               if (data_rvalid_i) begin
                  data_reg  <= load_fmt;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: stores, loads at every offset, misaligned accesses,
// reset mid-transaction, spurious handshakes and back-to-back issue.
module tb_miriscv_lsu;
   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   logic        clk_i;
   logic        arstn_i;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_data_i;
   logic [31:0] lsu_data_o;
   logic        lsu_stall_req_o;
   logic        lsu_misaligned_o;
   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   int n_vec  = 0;
   int n_miss = 0;

   miriscv_lsu dut (
      .clk_i            (clk_i),
      .arstn_i          (arstn_i),
      .lsu_req_i        (lsu_req_i),
      .lsu_we_i         (lsu_we_i),
      .lsu_size_i       (lsu_size_i),
      .lsu_addr_i       (lsu_addr_i),
      .lsu_data_i       (lsu_data_i),
      .lsu_data_o       (lsu_data_o),
      .lsu_stall_req_o  (lsu_stall_req_o),
      .lsu_misaligned_o (lsu_misaligned_o),
      .data_req_o       (data_req_o),
      .data_we_o        (data_we_o),
      .data_be_o        (data_be_o),
      .data_addr_o      (data_addr_o),
      .data_wdata_o     (data_wdata_o),
      .data_gnt_i       (data_gnt_i),
      .data_rvalid_i    (data_rvalid_i),
      .data_rdata_i     (data_rdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      lsu_req_i     = 1'b0;
      lsu_we_i      = 1'b0;
      lsu_size_i    = LDST_W;
      lsu_addr_i    = 32'd0;
      lsu_data_i    = 32'd0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = 32'd0;
   endtask

   // Drives one instruction from posedge+1 until its done cycle; returns at posedge+1 after it.
   task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gnt_dly, input int rv_dly,
                          output int stalls, output logic [31:0] result,
                          output logic [3:0] be0, output logic [31:0] addr0,
                          output logic [31:0] wd0, output logic ok);
      int  c;
      logic done;
      stalls = 0; result = 32'd0; ok = 1'b1; done = 1'b0; c = 0;
      be0 = 4'd0; addr0 = 32'd0; wd0 = 32'd0;
      lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr;
      lsu_data_i = wdata; data_rdata_i = rdata;
      while (!done && c < 64) begin
         data_gnt_i    = (c == gnt_dly);
         data_rvalid_i = !we && (c == gnt_dly + rv_dly);
         @(negedge clk_i);
         if (lsu_stall_req_o) stalls++;
         if (c == 0) begin
            be0 = data_be_o; addr0 = data_addr_o; wd0 = data_wdata_o;
         end
         if (c <= gnt_dly) begin
            if (!data_req_o || data_be_o !== be0 || data_addr_o !== addr0
                || data_wdata_o !== wd0 || data_we_o !== we) ok = 1'b0;
         end else if (data_req_o) ok = 1'b0;
         if (we ? (c == gnt_dly) : (c == gnt_dly + rv_dly)) begin
            done = 1'b1;
            result = lsu_data_o;
         end
         @(posedge clk_i); #1;
         c++;
      end
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
      if (!done) chk("txn_timeout", 32'd0, 32'd1);
      $display("txn we=%0d size=%0d addr=0x%08h stalls=%0d be=%b result=0x%08h",
               we, size, addr, stalls, be0, result);
   endtask

   int          st;
   logic [31:0] res, ad, wd;
   logic [3:0]  be;
   logic        ok;
   logic [31:0] exp_b  [4];
   logic [31:0] exp_bu [4];
   logic [2:0]  bad_size [3];
   logic [31:0] bad_addr [3];

   initial begin
      exp_b  = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
      exp_bu = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};
      bad_size = '{LDST_W, LDST_H, 3'd3};
      bad_addr = '{32'h00000002, 32'h00000001, 32'h00000000};

      // Reset held with a live, legal request: status outputs forced low
      idle_inputs();
      arstn_i = 1'b0;
      lsu_req_i = 1'b1; lsu_size_i = LDST_W; data_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("rst_req",   32'(data_req_o), 32'd0);
      chk("rst_stall", 32'(lsu_stall_req_o), 32'd0);
      chk("rst_data",  lsu_data_o, 32'd0);
      @(posedge clk_i); #1;
      idle_inputs();
      arstn_i = 1'b1;
      @(negedge clk_i);
      chk("post_rst_data", lsu_data_o, 32'd0);
      @(posedge clk_i); #1;

      // SB 0x103, immediate grant
      run_txn(1'b1, LDST_B, 32'h103, 32'hA5, 32'd0, 0, 0, st, res, be, ad, wd, ok);
      chk("sb_be",    32'(be), 32'h8);
      chk("sb_wdata", wd, 32'hA5A5A5A5);
      chk("sb_addr",  ad, 32'h100);
      chk("sb_stall", 32'(st), 32'd0);
      idle_inputs();

      // SH 0x006, grant after 3 cycles
      run_txn(1'b1, LDST_H, 32'h006, 32'h1234BEEF, 32'd0, 3, 0, st, res, be, ad, wd, ok);
      chk("sh_be",     32'(be), 32'hC);
      chk("sh_wdata",  wd, 32'hBEEFBEEF);
      chk("sh_stall",  32'(st), 32'd3);
      chk("sh_stable", 32'(ok), 32'd1);
      idle_inputs();

      // LH / LHU 0x202, gnt after 2, rvalid 3 after gnt
      run_txn(1'b0, LDST_H, 32'h202, 32'd0, 32'h80011234, 2, 3, st, res, be, ad, wd, ok);
      chk("lh_stall",  32'(st), 32'd5);
      chk("lh_be",     32'(be), 32'hC);
      chk("lh_data",   res, 32'hFFFF8001);
      chk("lh_stable", 32'(ok), 32'd1);
      idle_inputs();
      @(negedge clk_i);
      chk("lh_hold", lsu_data_o, 32'hFFFF8001);
      @(posedge clk_i); #1;
      run_txn(1'b0, LDST_HU, 32'h202, 32'd0, 32'h80011234, 2, 3, st, res, be, ad, wd, ok);
      chk("lhu_stall", 32'(st), 32'd5);
      chk("lhu_data",  res, 32'h00008001);
      idle_inputs();

      // Byte loads at every offset, then a word load
      for (int i = 0; i < 4; i++) begin
         run_txn(1'b0, LDST_B, 32'h300 + 32'(i), 32'd0, 32'h80FF7F01, 0, 1,
                 st, res, be, ad, wd, ok);
         chk("lb_data", res, exp_b[i]);
         chk("lb_be",   32'(be), 32'(4'b0001 << i));
         run_txn(1'b0, LDST_BU, 32'h300 + 32'(i), 32'd0, 32'h80FF7F01, 0, 1,
                 st, res, be, ad, wd, ok);
         chk("lbu_data",  res, exp_bu[i]);
         chk("lbu_stall", 32'(st), 32'd1);
      end
      run_txn(1'b0, LDST_W, 32'h300, 32'd0, 32'h80FF7F01, 0, 1, st, res, be, ad, wd, ok);
      chk("lw_data", res, 32'h80FF7F01);
      chk("lw_be",   32'(be), 32'hF);
      idle_inputs();

      // Misaligned / illegal: LW 0x002, SH 0x001, size 3
      for (int i = 0; i < 3; i++) begin
         lsu_req_i = 1'b1; lsu_we_i = (i == 1); lsu_size_i = bad_size[i];
         lsu_addr_i = bad_addr[i];
         @(negedge clk_i);
         chk("mis_flag",  32'(lsu_misaligned_o), 32'd1);
         chk("mis_req",   32'(data_req_o), 32'd0);
         chk("mis_stall", 32'(lsu_stall_req_o), 32'd0);
         @(posedge clk_i); #1;
         $display("txn misaligned size=%0d addr=0x%08h", bad_size[i], bad_addr[i]);
      end
      idle_inputs();

      // Reset while waiting for rvalid; late rvalid must be dropped
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h10;
      data_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("rr_req", 32'(data_req_o), 32'd1);
      @(posedge clk_i); #1;
      data_gnt_i = 1'b0;
      @(negedge clk_i);
      chk("rr_wait_stall", 32'(lsu_stall_req_o), 32'd1);
      chk("rr_wait_req",   32'(data_req_o), 32'd0);
      #1 arstn_i = 1'b0;
      #1;
      chk("rr_in_rst_stall", 32'(lsu_stall_req_o), 32'd0);
      chk("rr_in_rst_data",  lsu_data_o, 32'd0);
      @(posedge clk_i); #1;
      arstn_i = 1'b1;
      lsu_req_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
      @(negedge clk_i);
      chk("rr_rv_data",  lsu_data_o, 32'd0);
      chk("rr_rv_stall", 32'(lsu_stall_req_o), 32'd0);
      chk("rr_rv_req",   32'(data_req_o), 32'd0);
      @(posedge clk_i); #1;
      data_rvalid_i = 1'b0;
      @(negedge clk_i);
      chk("rr_after_data", lsu_data_o, 32'd0);
      @(posedge clk_i); #1;
      $display("txn reset during WAIT_RVALID");

      // Load a known value, then spurious gnt/rvalid with no request
      run_txn(1'b0, LDST_W, 32'h20, 32'd0, 32'h13572468, 0, 2, st, res, be, ad, wd, ok);
      chk("pre_sp_data", res, 32'h13572468);
      idle_inputs();
      data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
      @(negedge clk_i);
      chk("sp_req",   32'(data_req_o), 32'd0);
      chk("sp_stall", 32'(lsu_stall_req_o), 32'd0);
      chk("sp_data",  lsu_data_o, 32'h13572468);
      @(posedge clk_i); #1;
      idle_inputs();
      $display("txn spurious gnt/rvalid");

      // Back-to-back SW then LW with no bubble
      run_txn(1'b1, LDST_W, 32'h40, 32'h11223344, 32'd0, 0, 0, st, res, be, ad, wd, ok);
      chk("b2b_sw_stall", 32'(st), 32'd0);
      chk("b2b_sw_wdata", wd, 32'h11223344);
      chk("b2b_sw_be",    32'(be), 32'hF);
      run_txn(1'b0, LDST_W, 32'h44, 32'd0, 32'hCAFEF00D, 0, 1, st, res, be, ad, wd, ok);
      chk("b2b_lw_issue", 32'(ok), 32'd1);
      chk("b2b_lw_addr",  ad, 32'h44);
      chk("b2b_lw_data",  res, 32'hCAFEF00D);
      chk("b2b_lw_stall", 32'(st), 32'd1);
      idle_inputs();
      @(posedge clk_i); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
